// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - walks a register range through one read port and streams it out with an XOR checksum
module reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [4:0]        dump_index,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD,
        DONE
    } state_t;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    state_t state;

    // busy and done are registered from the next state so they line up with the state itself
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_addr    <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_index <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            checksum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        rd_addr  <= FIRST_IDX;
                        checksum <= '0;
                        busy     <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        dump_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        dump_data  <= rd_data;
                        dump_index <= rd_addr;
                        dump_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    // abort wins over a simultaneous handshake; the partial checksum is kept
                    if (abort) begin
                        dump_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (dump_ready) begin
                        checksum   <= checksum ^ dump_data;
                        dump_valid <= 1'b0;
                        if (dump_index == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            rd_addr <= rd_addr + 5'd1;
                            state   <= READ;
                        end
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    dump_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    dump_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// tb/tb_reg_dump.sv - randomized directed bench for reg_dump against a range/XOR reference model
module tb_reg_dump;

    logic        clk;
    logic        reset;

    logic        f_start, f_abort, f_ready;
    logic [4:0]  f_rd_addr;
    logic [31:0] f_rd_data;
    logic        f_valid;
    logic [31:0] f_data;
    logic [4:0]  f_index;
    logic        f_busy, f_done;
    logic [31:0] f_csum;

    logic        p_start, p_abort, p_ready;
    logic [4:0]  p_rd_addr;
    logic [31:0] p_rd_data;
    logic        p_valid;
    logic [31:0] p_data;
    logic [4:0]  p_index;
    logic        p_busy, p_done;
    logic [31:0] p_csum;

    logic [31:0] rf_f [0:31];
    logic [31:0] rf_p [0:31];

    int total = 0;
    int bad   = 0;

    assign f_rd_data = rf_f[f_rd_addr];
    assign p_rd_data = rf_p[p_rd_addr];

    reg_dump #(.FIRST_REG(0), .LAST_REG(31), .DATA_W(32)) dut_full (
        .clk(clk), .reset(reset), .start(f_start), .abort(f_abort),
        .rd_addr(f_rd_addr), .rd_data(f_rd_data),
        .dump_valid(f_valid), .dump_ready(f_ready),
        .dump_data(f_data), .dump_index(f_index),
        .busy(f_busy), .done(f_done), .checksum(f_csum)
    );

    reg_dump #(.FIRST_REG(1), .LAST_REG(3), .DATA_W(32)) dut_part (
        .clk(clk), .reset(reset), .start(p_start), .abort(p_abort),
        .rd_addr(p_rd_addr), .rd_data(p_rd_data),
        .dump_valid(p_valid), .dump_ready(p_ready),
        .dump_data(p_data), .dump_index(p_index),
        .busy(p_busy), .done(p_done), .checksum(p_csum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) rf_f[i] = $urandom();
    endtask

    // Model: words FIRST..LAST in order, each stable until accepted, checksum = XOR of accepted words
    task automatic dump_run(input int stall_idx, input int stall_len, input int abort_idx,
                            input int reset_idx, input int start_idx, input bit rand_ready,
                            output int done_cycle);
        int          exp_i, stalled, cyc;
        logic [31:0] csum_m;
        bit          fin, prev_hold;
        exp_i = 0; stalled = 0; csum_m = '0; fin = 0; prev_hold = 0; done_cycle = -1;
        f_start = 1'b1; f_ready = 1'b1;
        @(negedge clk);
        f_start = 1'b0; cyc = 1;
        chk("start_clears_csum", f_csum, 32'h0);
        chk("start_busy", {31'b0, f_busy}, 32'h1);
        while (!fin && cyc < 800) begin
            f_start = 1'b0;
            if (prev_hold) chk("hold_valid", {31'b0, f_valid}, 32'h1);
            prev_hold = 0;
            if (done_cycle >= 0) begin
                for (int k = 0; k < 3; k++) begin
                    chk("post_done_low", {31'b0, f_done}, 32'h0);
                    chk("post_done_idle", {31'b0, f_busy}, 32'h0);
                    chk("post_done_csum", f_csum, csum_m);
                    @(negedge clk);
                end
                fin = 1;
            end else if (f_done) begin
                done_cycle = cyc;
                chk("done_after_last", exp_i, 32);
                chk("done_csum", f_csum, csum_m);
            end else if (f_valid) begin
                chk("index", {27'b0, f_index}, exp_i);
                chk("data", f_data, rf_f[exp_i[4:0]]);
                if (exp_i == reset_idx) begin
                    reset = 1'b1; f_ready = 1'b0;
                    @(negedge clk);
                    reset = 1'b0;
                    chk("rst_rd_addr", {27'b0, f_rd_addr}, 32'h0);
                    chk("rst_valid", {31'b0, f_valid}, 32'h0);
                    chk("rst_data", f_data, 32'h0);
                    chk("rst_index", {27'b0, f_index}, 32'h0);
                    chk("rst_busy", {31'b0, f_busy}, 32'h0);
                    chk("rst_done", {31'b0, f_done}, 32'h0);
                    chk("rst_csum", f_csum, 32'h0);
                    @(negedge clk);
                    chk("rst_stays_idle", {31'b0, f_busy}, 32'h0);
                    fin = 1;
                end else if (exp_i == abort_idx) begin
                    f_abort = 1'b1; f_ready = 1'b0;
                    @(negedge clk);
                    f_abort = 1'b0;
                    chk("abort_busy", {31'b0, f_busy}, 32'h0);
                    chk("abort_valid", {31'b0, f_valid}, 32'h0);
                    chk("abort_done", {31'b0, f_done}, 32'h0);
                    chk("abort_csum", f_csum, csum_m);
                    chk("abort_rd_addr", {27'b0, f_rd_addr}, exp_i);
                    @(negedge clk);
                    chk("abort_no_done", {31'b0, f_done}, 32'h0);
                    chk("abort_idle", {31'b0, f_busy}, 32'h0);
                    fin = 1;
                end else begin
                    if (exp_i == start_idx) f_start = 1'b1;
                    if (exp_i == stall_idx && stalled < stall_len) begin
                        f_ready = 1'b0;
                        stalled++;
                    end else begin
                        f_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                    if (f_ready) begin
                        csum_m ^= rf_f[exp_i[4:0]];
                        exp_i++;
                    end else begin
                        prev_hold = 1;
                    end
                end
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) chk("dump_timeout", 32'h0, 32'h1);
        f_start = 1'b0; f_abort = 1'b0; f_ready = 1'b1;
    endtask

    initial begin
        int          dc;
        int          pc;
        bit          p_seen_done;
        logic [4:0]  p_idx_q [$];
        logic [31:0] p_dat_q [$];

        reset = 1'b1;
        f_start = 1'b0; f_abort = 1'b0; f_ready = 1'b1;
        p_start = 1'b0; p_abort = 1'b0; p_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rf_f[i] = (i == 0) ? 32'h0 : (32'h1 << i);
            rf_p[i] = $urandom();
        end
        rf_p[1] = 32'h1; rf_p[2] = 32'h2; rf_p[3] = 32'h4;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_rd_addr", {27'b0, f_rd_addr}, 32'h0);
        chk("reset_valid", {31'b0, f_valid}, 32'h0);
        chk("reset_data", f_data, 32'h0);
        chk("reset_index", {27'b0, f_index}, 32'h0);
        chk("reset_busy", {31'b0, f_busy}, 32'h0);
        chk("reset_done", {31'b0, f_done}, 32'h0);
        chk("reset_csum", f_csum, 32'h0);
        @(negedge clk);

        // one-hot pattern, ready held high: done lands in cycle 65
        dump_run(-1, 0, -1, -1, -1, 1'b0, dc);
        chk("pattern_done_cycle", dc, 65);
        chk("pattern_csum", f_csum, 32'hFFFF_FFFE);

        f_start = 1'b1; f_abort = 1'b1;
        @(negedge clk);
        f_start = 1'b0; f_abort = 1'b0;
        chk("start_abort_busy", {31'b0, f_busy}, 32'h0);
        chk("start_abort_rd_addr", {27'b0, f_rd_addr}, 32'd31);
        @(negedge clk);
        chk("start_abort_still_idle", {31'b0, f_busy}, 32'h0);

        p_start = 1'b1;
        @(negedge clk);
        p_start = 1'b0;
        p_seen_done = 0;
        for (int c = 0; c < 40 && !p_seen_done; c++) begin
            if (p_valid) begin
                p_idx_q.push_back(p_index);
                p_dat_q.push_back(p_data);
            end
            if (p_done) p_seen_done = 1;
            @(negedge clk);
        end
        pc = p_idx_q.size();
        chk("part_done_seen", {31'b0, p_seen_done}, 32'h1);
        chk("part_word_count", pc, 3);
        for (int i = 0; i < 3 && i < pc; i++) begin
            chk("part_index", {27'b0, p_idx_q[i]}, i + 1);
            chk("part_data", p_dat_q[i], rf_p[i + 1]);
        end
        chk("part_csum", p_csum, 32'h7);

        fill_random();
        dump_run(4, 5, -1, -1, -1, 1'b0, dc);
        chk("stall_done_seen", {31'b0, dc > 0}, 32'h1);

        fill_random();
        dump_run(-1, 0, 10, -1, -1, 1'b1, dc);
        dump_run(-1, 0, -1, -1, -1, 1'b1, dc);
        chk("restart_done_seen", {31'b0, dc > 0}, 32'h1);

        fill_random();
        dump_run(-1, 0, -1, -1, 7, 1'b0, dc);
        chk("start_busy_done_cycle", dc, 65);

        fill_random();
        dump_run(-1, 0, -1, 20, -1, 1'b0, dc);
        dump_run(-1, 0, -1, -1, -1, 1'b0, dc);
        chk("post_reset_done_cycle", dc, 65);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            dump_run($urandom_range(0, 31), $urandom_range(1, 6), -1, -1, -1, 1'b1, dc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
Name: reg_dump

Overview:
Debug readout engine that walks a contiguous range of architectural registers through one register-file read port. Each value is streamed out on a valid/ready interface tagged with its index, and a running XOR checksum is kept. It is the reader counterpart to the register file. It drives a read address and consumes the combinational read data. It sits beside the CPU core, and the testbench or debug host uses it to extract processor state after program execution.

Parameters:
FIRST_REG, 0, first register index dumped (0..31)
LAST_REG, 31, last register index dumped (FIRST_REG..31)
DATA_W, 32, register data width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a dump; sampled only in IDLE
abort  input  1  cancel an in-progress dump
rd_addr  output  5  read address to the register-file read port (registered)
rd_data  input  DATA_W  combinational read data returned for rd_addr
dump_valid  output  1  dump_data/dump_index hold a valid word
dump_ready  input  1  consumer accepts the word when valid&ready
dump_data  output  DATA_W  captured register value
dump_index  output  5  register index of dump_data
busy  output  1  high in READ, HOLD and DONE
done  output  1  one-cycle pulse when the full range is accepted
checksum  output  DATA_W  XOR of all accepted words of the current/last dump

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and reset.
- Reset takes effect at the next rising edge regardless of state, including mid-dump. After reset: state=IDLE, rd_addr=0, dump_valid=0, dump_data=0, dump_index=0, busy=0, done=0, checksum=0.
- FSM states: IDLE, READ, HOLD, DONE.
- IDLE:
  - start=1 and abort=0: rd_addr<=FIRST_REG, checksum<=0, go to READ.
  - Otherwise stay in IDLE. rd_addr, dump_data, dump_index and checksum hold.
- READ (1 cycle):
  - dump_data<=rd_data and dump_index<=rd_addr.
  - dump_valid<=1, go to HOLD.
- HOLD:
  - dump_valid=1. dump_data and dump_index stay stable until accepted.
  - On dump_ready=1: checksum<=checksum^dump_data and dump_valid<=0.
  - If dump_index==LAST_REG, go to DONE. Otherwise rd_addr<=rd_addr+1 and go to READ.
  - On dump_ready=0: stay in HOLD, all outputs unchanged.
- DONE (1 cycle): done=1 for exactly this cycle, then go to IDLE. checksum holds its final value until the next start.
- Throughput: one word per 2 cycles when dump_ready is held high. A full 0..31 dump occupies 64 cycles of READ/HOLD plus 1 DONE cycle.
- The register at index 0 is read through the port like any other. The block never forces its value.
- start in any state other than IDLE is ignored.
- abort in READ, HOLD or DONE:
  - Next state is IDLE and dump_valid<=0. done is not pulsed.
  - checksum keeps its partial value.
  - In DONE, the done pulse of that cycle still shows, because abort only affects the next state.
- abort together with start in IDLE: abort wins and the FSM stays in IDLE.
- The index counter never wraps. Termination is by the compare with LAST_REG, so LAST_REG=31 is the final index.
- rd_addr is updated only by the FSM and never changes combinationally from inputs.
- Arithmetic: checksum is a bitwise XOR across DATA_W bits. Index increment is 5-bit.

Test Plan:
- Register file preloaded x_i=1<<i (x0=0), dump_ready tied 1, start pulsed at edge E0:
  - 32 handshakes occur, with indices 0..31 in order and data 0,2,4,…,0x80000000.
  - done is high only in cycle 65 after E0.
  - checksum=0xFFFFFFFE, and busy=0 from cycle 66.
- FIRST_REG=1, LAST_REG=3, x1=0x1, x2=0x2, x3=0x4: exactly 3 words (1:0x1, 2:0x2, 3:0x4) are delivered and checksum=0x7.
- Backpressure: dump_ready low for 5 cycles during the word for index 4. dump_valid stays 1, and dump_data/dump_index stay (x4, 4) for all 5 cycles. After ready rises there is no duplicate and no skip, and index 5 follows.
- abort asserted in HOLD while index 10 is pending (ready=0): the next cycle is IDLE with dump_valid=0 and no done pulse. checksum equals the XOR of x0..x9. A new start restarts at FIRST_REG with checksum cleared.
- start asserted while busy at index 7: the sequence is unaffected and a single done pulse is produced. start and abort together in IDLE: busy stays 0 and rd_addr is unchanged.
- reset asserted mid-dump at index 20 with dump_valid=1: at the next edge all outputs take their reset values and the state is IDLE. A subsequent start performs a complete, correct dump.
